// File: rtl/sr_bcast_pkg.sv
// Shared sizing helpers and parameter legality check for the broadcast buffer.
package sr_bcast_pkg;

   localparam int unsigned MAX_NCH = 16;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit params_ok(input int unsigned width,
                                    input int unsigned nch,
                                    input int unsigned depth);
      return (width >= 1) && (nch >= 1) && (nch <= MAX_NCH) &&
             (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sr_bcast_if.sv
// Producer-side and consumer-side handshake bundle of the broadcast buffer.
interface sr_bcast_if
   import sr_bcast_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = lvl_w(DEPTH);

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic [NCH-1:0]         out_valid;
   logic [NCH-1:0]         out_ready;
   logic [NCH*WIDTH-1:0]   out_data;
   logic [LW-1:0]          level;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level
   );

endinterface

// File: rtl/sr_bcast_mem.sv
// DEPTH x WIDTH word storage: one synchronous write port, one asynchronous read port.
module sr_bcast_mem
   import sr_bcast_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sr_bcast_buf.sv
// Broadcast FIFO: one producer, NCH consumers; a word retires once every channel took it.
module sr_bcast_buf
   import sr_bcast_pkg::*;
#(
   parameter int unsigned   WIDTH    = 8,
   parameter int unsigned   NCH      = 4,
   parameter int unsigned   DEPTH    = 4,
   parameter logic [NCH-1:0] INV_MASK = '0
) (
   input  logic     clk,
   input  logic     rst_n,
   sr_bcast_if.slave bus
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned LW = lvl_w(DEPTH);

   if (!params_ok(WIDTH, NCH, DEPTH)) begin : g_bad_params
      $error("sr_bcast_buf: illegal WIDTH/NCH/DEPTH combination");
   end

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q,  level_d;
   logic [NCH-1:0]   done_q,   done_d;
   logic [NCH-1:0]   out_valid_c;
   logic [NCH-1:0]   accept_c;
   logic             push_c, pop_c, nonempty_c, in_ready_c;
   logic [WIDTH-1:0] head_c;

   sr_bcast_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push_c),
      .waddr (wr_ptr_q),
      .wdata (bus.in_data),
      .raddr (rd_ptr_q),
      .rdata (head_c)
   );

   // Handshake decode and next-state; in_ready and out_valid come only from flops.
   always_comb begin
      nonempty_c  = (level_q != LW'(0));
      in_ready_c  = (level_q != LW'(DEPTH));
      out_valid_c = {NCH{nonempty_c}} & ~done_q;
      accept_c    = out_valid_c & bus.out_ready;
      push_c      = bus.in_valid & in_ready_c;
      pop_c       = nonempty_c & (&(done_q | accept_c));

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      done_d   = done_q | accept_c;

      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         done_d   = '0;
      end
      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         done_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         done_q   <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.level     = level_q;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign bus.out_data[c*WIDTH +: WIDTH] = head_c ^ {WIDTH{INV_MASK[c]}};
   end

endmodule

// File: tb/tb_sr_bcast_buf.sv
// Directed self-checking bench for sr_bcast_buf (WIDTH=8, NCH=4, DEPTH=4, INV_MASK=0101).
`timescale 1ns/1ps
module tb_sr_bcast_buf;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NCH   = 4;
   localparam int unsigned DEPTH = 4;
   localparam logic [3:0]  INV   = 4'b0101;
   localparam int unsigned NSTREAM = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   sr_bcast_if #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) bus ();

   sr_bcast_buf #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .INV_MASK(INV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ch_data(input int c);
      logic [NCH*WIDTH-1:0] v;
      v = bus.out_data;
      return v[c*WIDTH +: WIDTH];
   endfunction

   function automatic logic [7:0] inv_of(input int c, input logic [7:0] w);
      logic [3:0] m;
      m = INV;
      return m[c] ? ~w : w;
   endfunction

   function automatic logic [7:0] stream_word(input int k);
      return 8'(k * 37 + 5);
   endfunction

   task automatic push_one(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int cnt [NCH];
      int pushed;
      int cycles;
      logic [3:0] acc;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = '0;

      // Reset state
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_level", 32'(bus.level), 32'd0);
      rst_n = 1'b1;
      step();

      // Single word with inversion
      bus.out_ready = 4'hF;
      push_one(8'hA5);
      chk("single_valid", 32'(bus.out_valid), 32'hF);
      chk("single_ch0", 32'(ch_data(0)), 32'h5A);
      chk("single_ch1", 32'(ch_data(1)), 32'hA5);
      chk("single_ch2", 32'(ch_data(2)), 32'h5A);
      chk("single_ch3", 32'(ch_data(3)), 32'hA5);
      chk("single_level", 32'(bus.level), 32'd1);
      step();
      chk("single_drain_valid", 32'(bus.out_valid), 32'h0);
      chk("single_drain_level", 32'(bus.level), 32'd0);

      // Fill to full, extra push ignored
      bus.out_ready = 4'h0;
      push_one(8'h11);
      push_one(8'h22);
      push_one(8'h33);
      push_one(8'h44);
      chk("full_level", 32'(bus.level), 32'd4);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      push_one(8'h99);
      chk("full_ignore_level", 32'(bus.level), 32'd4);
      chk("full_head_ch1", 32'(ch_data(1)), 32'h11);
      chk("full_head_ch0", 32'(ch_data(0)), 32'hEE);

      // Staggered per-channel acceptance
      bus.out_ready = 4'b0001;
      step();
      chk("stag_t0_valid", 32'(bus.out_valid), 32'hE);
      bus.out_ready = 4'b0010;
      step();
      chk("stag_t1_valid", 32'(bus.out_valid), 32'hC);
      chk("stag_t1_level", 32'(bus.level), 32'd4);
      bus.out_ready = 4'b0000;
      step();
      chk("stag_t2_valid", 32'(bus.out_valid), 32'hC);
      bus.out_ready = 4'b1100;
      step();
      bus.out_ready = 4'b0000;
      chk("stag_pop_valid", 32'(bus.out_valid), 32'hF);
      chk("stag_pop_ch1", 32'(ch_data(1)), 32'h22);
      chk("stag_pop_level", 32'(bus.level), 32'd3);
      push_one(8'h66);
      chk("refill_level", 32'(bus.level), 32'd4);

      // Full: pop only, then simultaneous push and pop
      bus.out_ready = 4'hF;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      step();
      chk("fullpp_c1_level", 32'(bus.level), 32'd3);
      chk("fullpp_c1_ready", 32'(bus.in_ready), 32'd1);
      chk("fullpp_c1_ch1", 32'(ch_data(1)), 32'h33);
      step();
      bus.in_valid = 1'b0;
      chk("fullpp_c2_level", 32'(bus.level), 32'd3);
      chk("fullpp_c2_ch1", 32'(ch_data(1)), 32'h44);
      step();
      chk("drain_ch1_66", 32'(ch_data(1)), 32'h66);
      step();
      chk("drain_ch1_55", 32'(ch_data(1)), 32'h55);
      chk("drain_ch2_55", 32'(ch_data(2)), 32'hAA);
      step();
      chk("drain_empty_valid", 32'(bus.out_valid), 32'h0);
      chk("drain_empty_level", 32'(bus.level), 32'd0);

      // Streaming with random per-channel ready
      for (int c = 0; c < NCH; c++) cnt[c] = 0;
      pushed = 0;
      cycles = 0;
      while ((cnt[0] < NSTREAM || cnt[1] < NSTREAM || cnt[2] < NSTREAM ||
              cnt[3] < NSTREAM) && cycles < 6000) begin
         bus.out_ready = 4'($urandom_range(0, 15));
         bus.in_valid  = (pushed < NSTREAM);
         bus.in_data   = stream_word(pushed);
         acc = bus.out_valid & bus.out_ready;
         for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
               chk($sformatf("stream_ch%0d_w%0d", c, cnt[c]), 32'(ch_data(c)),
                   32'(inv_of(c, stream_word(cnt[c]))));
               cnt[c]++;
            end
         end
         if (bus.in_valid && bus.in_ready) pushed++;
         step();
         cycles++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'h0;
      for (int c = 0; c < NCH; c++)
         chk($sformatf("stream_count_ch%0d", c), 32'(cnt[c]), 32'(NSTREAM));
      chk("stream_end_level", 32'(bus.level), 32'd0);

      // Asynchronous reset mid-stream
      push_one(8'hA1);
      push_one(8'hA2);
      push_one(8'hA3);
      bus.out_ready = 4'b0011;
      step();
      bus.out_ready = 4'b0000;
      chk("mid_pre_valid", 32'(bus.out_valid), 32'hC);
      chk("mid_pre_level", 32'(bus.level), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_level", 32'(bus.level), 32'd0);
      #1 rst_n = 1'b1;
      bus.out_ready = 4'hF;
      push_one(8'hC3);
      chk("post_rst_valid", 32'(bus.out_valid), 32'hF);
      chk("post_rst_ch0", 32'(ch_data(0)), 32'h3C);
      chk("post_rst_ch3", 32'(ch_data(3)), 32'hC3);
      chk("post_rst_level", 32'(bus.level), 32'd1);
      step();
      chk("post_rst_drain", 32'(bus.level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
